// File: rtl/scan_xfer_buffer.sv
// Shared transfer FIFO arbitrated between two scanners with a one-cycle flush state.
// Optional 7-segment status outputs are enabled with `define SCAN_XFER_BUFFER_HEX_EN.
module scan_xfer_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             valid_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             flush,
    input  logic             rd_en,
    output logic             grant_a,
    output logic             grant_b,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [3:0]       level,
    output logic             full,
    output logic             empty,
`ifdef SCAN_XFER_BUFFER_HEX_EN
    output logic [6:0]       state_hex,
    output logic [6:0]       level_hex,
`endif
    output logic             overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, FLUSH} state_t;

    state_t state, next_state;
    logic last_b;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic wr_req, clearing, wr_ok, wr_drop, pop;
    logic [WIDTH-1:0] wr_word;

    // last_b remembers who was served most recently so ties alternate
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT_A)
                last_b <= 1'b0;
            else if (state == IDLE && next_state == GRANT_B)
                last_b <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (flush)
                    next_state = FLUSH;
                else if (req_a && req_b)
                    next_state = last_b ? GRANT_A : GRANT_B;
                else if (req_a)
                    next_state = GRANT_A;
                else if (req_b)
                    next_state = GRANT_B;
            end
            GRANT_A: begin
                if (flush)
                    next_state = FLUSH;
                else if (!req_a)
                    next_state = IDLE;
            end
            GRANT_B: begin
                if (flush)
                    next_state = FLUSH;
                else if (!req_b)
                    next_state = IDLE;
            end
            FLUSH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_a = (state == GRANT_A);
        grant_b = (state == GRANT_B);
`ifdef SCAN_XFER_BUFFER_HEX_EN
        state_hex = 7'b0111111;
        case (state)
            GRANT_A: state_hex = 7'b0001000;
            GRANT_B: state_hex = 7'b0000011;
            FLUSH:   state_hex = 7'b0001110;
            default: state_hex = 7'b0111111;
        endcase
        level_hex = 7'b1000000;
        case (level)
            4'h0: level_hex = 7'b1000000;
            4'h1: level_hex = 7'b1111001;
            4'h2: level_hex = 7'b0100100;
            4'h3: level_hex = 7'b0110000;
            4'h4: level_hex = 7'b0011001;
            4'h5: level_hex = 7'b0010010;
            4'h6: level_hex = 7'b0000010;
            4'h7: level_hex = 7'b1111000;
            4'h8: level_hex = 7'b0000000;
            4'h9: level_hex = 7'b0010000;
            4'hA: level_hex = 7'b0001000;
            4'hB: level_hex = 7'b0000011;
            4'hC: level_hex = 7'b1000110;
            4'hD: level_hex = 7'b0100001;
            4'hE: level_hex = 7'b0000110;
            default: level_hex = 7'b0001110;
        endcase
`endif
    end

    // Only the granted scanner can write; a flush request or the flush state blocks all traffic
    assign wr_req   = (state == GRANT_A && valid_a) || (state == GRANT_B && valid_b);
    assign wr_word  = (state == GRANT_B) ? data_b : data_a;
    assign clearing = flush || (state == FLUSH);
    assign wr_ok    = wr_req && !clearing && (level != DEPTH_L);
    assign wr_drop  = wr_req && !clearing && (level == DEPTH_L);
    assign pop      = rd_en && !clearing && (level != 4'd0);

    assign full  = (level == DEPTH_L);
    assign empty = (level == 4'd0);

    always_ff @(posedge clk) begin
        if (wr_ok && !reset)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= 4'd0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clearing) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= 4'd0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_ok)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (wr_drop)
                overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_xfer_buffer.sv
// Scoreboard bench for scan_xfer_buffer: accepted writes are queued, pops are checked against the queue.
// Hex status checks are compiled in when SCAN_XFER_BUFFER_HEX_EN is defined.
module tb_scan_xfer_buffer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset, req_a, req_b, valid_a, valid_b, flush, rd_en;
    logic [WIDTH-1:0] data_a, data_b;
    logic grant_a, grant_b, rd_valid, full, empty, overflow;
    logic [WIDTH-1:0] rd_data;
    logic [3:0] level;
`ifdef SCAN_XFER_BUFFER_HEX_EN
    logic [6:0] state_hex, level_hex;
`endif

    int total = 0;
    int bad = 0;
    logic [WIDTH-1:0] exp_q[$];
    int m_level = 0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    scan_xfer_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .valid_a(valid_a), .valid_b(valid_b),
        .data_a(data_a), .data_b(data_b),
        .flush(flush), .rd_en(rd_en),
        .grant_a(grant_a), .grant_b(grant_b),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .full(full), .empty(empty),
`ifdef SCAN_XFER_BUFFER_HEX_EN
        .state_hex(state_hex), .level_hex(level_hex),
`endif
        .overflow(overflow)
    );

    // One granted-session cycle: model updates from pre-cycle level, then outputs are checked
    task automatic xfer_cycle(input logic use_b, input logic va, input logic [7:0] d, input logic rd);
        logic do_pop;
        logic [7:0] exp_word;
        int pre;
        pre = m_level;
        do_pop = rd && (pre > 0);
        exp_word = 8'h00;
        if (do_pop) begin
            exp_word = exp_q.pop_front();
            m_level--;
        end
        if (va && pre < DEPTH) begin
            exp_q.push_back(d);
            m_level++;
        end
        if (va && pre == DEPTH)
            m_ovf = 1'b1;
        valid_a = va && !use_b;
        valid_b = va && use_b;
        data_a = d;
        data_b = d;
        rd_en = rd;
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        rd_en = 1'b0;
        total++;
        if (rd_valid !== do_pop) begin
            bad++;
            $display("[TB] FAIL rd_valid: got %b expected %b", rd_valid, do_pop);
        end
        if (do_pop) begin
            total++;
            if (rd_data !== exp_word) begin
                bad++;
                $display("[TB] FAIL rd_data: got %h expected %h", rd_data, exp_word);
            end
        end
        total++;
        if (level !== 4'(m_level)) begin
            bad++;
            $display("[TB] FAIL level: got %0d expected %0d", level, m_level);
        end
        total++;
        if (overflow !== m_ovf) begin
            bad++;
            $display("[TB] FAIL overflow: got %b expected %b", overflow, m_ovf);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        flush = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_level = 0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({grant_a, grant_b, rd_valid, overflow, full} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {grant_a, grant_b, rd_valid, overflow, full});
        end
        total++;
        if (level !== 4'd0 || empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_level: got level=%0d empty=%b expected 0/1", level, empty);
        end
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req_a = 1'b1;
        @(posedge clk); #1;
        total++;
        if (grant_a !== 1'b1 || grant_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_grant: got %b%b expected 10", grant_a, grant_b);
        end
        xfer_cycle(1'b0, 1'b1, 8'h11, 1'b0);
        xfer_cycle(1'b0, 1'b1, 8'h22, 1'b0);
        xfer_cycle(1'b0, 1'b1, 8'h33, 1'b0);
        repeat (3) xfer_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_empty: got %b expected 1", empty);
        end
        xfer_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        req_a = 1'b0;
        @(posedge clk); #1;
        total++;
        if (grant_a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_release: got %b expected 0", grant_a);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        valid_a = 1'b1; data_a = 8'hEE;
        @(posedge clk); #1;
        valid_a = 1'b0;
        total++;
        if (level !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_valid: got level=%0d ovf=%b expected 0/0", level, overflow);
        end
        req_a = 1'b1; req_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({grant_a, grant_b} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL tie1: got %b%b expected 10", grant_a, grant_b);
        end
        valid_b = 1'b1; data_b = 8'hBB;
        @(posedge clk); #1;
        valid_b = 1'b0;
        total++;
        if (level !== 4'd0) begin
            bad++;
            $display("[TB] FAIL other_valid: got level=%0d expected 0", level);
        end
        req_a = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({grant_a, grant_b} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL release_a: got %b%b expected 00", grant_a, grant_b);
        end
        @(posedge clk); #1;
        total++;
        if ({grant_a, grant_b} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL serve_b: got %b%b expected 01", grant_a, grant_b);
        end
        req_b = 1'b0;
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({grant_a, grant_b} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL tie2: got %b%b expected 10", grant_a, grant_b);
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_overflow_wrap();
        do_reset();
        req_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++)
            xfer_cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        total++;
        if (full !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("[TB] FAIL full: got full=%b level=%0d expected 1/8", full, level);
        end
        xfer_cycle(1'b0, 1'b1, 8'h99, 1'b1);
        for (int i = 0; i < 10; i++)
            xfer_cycle(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1);
        repeat (7) xfer_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        total++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drain: got empty=%b ovf=%b expected 1/1", empty, overflow);
        end
        req_a = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        req_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++)
            xfer_cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        repeat (3) xfer_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        flush = 1'b1; valid_a = 1'b1; data_a = 8'hCC; rd_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; rd_en = 1'b0;
        exp_q.delete(); m_level = 0; m_ovf = 1'b0;
        total++;
        if (level !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_clear: got level=%0d ovf=%b rv=%b expected 0/0/0", level, overflow, rd_valid);
        end
        total++;
        if ({grant_a, grant_b} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL flush_state: got %b%b expected 00", grant_a, grant_b);
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        total++;
        if (level !== 4'd0 || {grant_a, grant_b} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL flush_idle: got level=%0d grants=%b%b expected 0/00", level, grant_a, grant_b);
        end
        @(posedge clk); #1;
        total++;
        if (grant_a !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_regrant: got %b expected 1", grant_a);
        end
        xfer_cycle(1'b0, 1'b1, 8'h77, 1'b0);
        xfer_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        req_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 1'b1;
        @(posedge clk); #1;
        xfer_cycle(1'b0, 1'b1, 8'h61, 1'b0);
        xfer_cycle(1'b0, 1'b1, 8'h62, 1'b0);
        reset = 1'b1; flush = 1'b1; rd_en = 1'b1; valid_a = 1'b1;
        @(posedge clk); #1;
        total++;
        if (level !== 4'd0 || {grant_a, grant_b} !== 2'b00 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_mid: got level=%0d grants=%b%b rv=%b rd=%h expected 0/00/0/00",
                     level, grant_a, grant_b, rd_valid, rd_data);
        end
        reset = 1'b0; flush = 1'b0; rd_en = 1'b0; valid_a = 1'b0; req_a = 1'b0;
    endtask

`ifdef SCAN_XFER_BUFFER_HEX_EN
    task automatic test_hex();
        do_reset();
        total++;
        if (state_hex !== 7'b0111111 || level_hex !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL hex_idle: got %b %b expected 0111111 1000000", state_hex, level_hex);
        end
        req_b = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            xfer_cycle(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        total++;
        if (state_hex !== 7'b0000011 || level_hex !== 7'b0000000) begin
            bad++;
            $display("[TB] FAIL hex_gb8: got %b %b expected 0000011 0000000", state_hex, level_hex);
        end
        req_b = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_overflow_wrap();
        test_flush();
        test_reset_mid();
`ifdef SCAN_XFER_BUFFER_HEX_EN
        test_hex();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
